io_port_ctrl: RTL and testbench

- Peripheral-side responder for the processor's 16-bit IN/OUT port pair.
- Buffers words from an external producer into an input FIFO. The processor consumes these words with IN instructions.
- Buffers words written by OUT instructions into an output FIFO. An external consumer drains it over a valid/ready handshake.
- Requests a pipeline stall when an IN hits an empty buffer or an OUT hits a full one.

---
 rtl/io_port_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_io_port_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// ---------------------------------------------------------------------------
// io_port_ctrl
//
// Peripheral-side responder for the processor's IN/OUT port pair.
//   - Input FIFO : an external producer pushes words over a valid/ready
//                  handshake. The processor pops them with IN instructions.
//                  The head word is presented first-word fall-through.
//   - Output FIFO: the processor pushes words with OUT instructions. An
//                  external consumer drains them over a valid/ready handshake.
//   - stall      : combinational request to hold the pipeline. It is raised
//                  when an IN finds the input FIFO empty, or when an OUT finds
//                  the output FIFO full. A stalled access changes no state.
//
// Optional build macro IOP_ERR_FLAGS_EN adds sticky error flags:
//   err_clr (in), err_underrun (out), err_overflow (out).
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   cpu_in_rd         IN consumes the head word this cycle
//   cpu_in_data       input FIFO head (last popped word when empty)
//   cpu_in_empty      input FIFO empty
//   cpu_out_wr        OUT writes cpu_out_data this cycle
//   cpu_out_data      word written by OUT
//   cpu_out_full      output FIFO full
//   stall             pipeline stall request (combinational)
//   ext_in_valid      producer presents ext_in_data
//   ext_in_ready      input FIFO can accept (registered "not full")
//   ext_in_data       producer word
//   ext_out_valid     output FIFO head available
//   ext_out_ready     consumer accepts the head word
//   ext_out_data      output FIFO head (last popped word when empty)
// ---------------------------------------------------------------------------
module io_port_ctrl #(
    parameter int DATA_W    = 16,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_in_rd,
    output logic [DATA_W-1:0] cpu_in_data,
    output logic              cpu_in_empty,
    input  logic              cpu_out_wr,
    input  logic [DATA_W-1:0] cpu_out_data,
    output logic              cpu_out_full,
    output logic              stall,
`ifdef IOP_ERR_FLAGS_EN
    input  logic              err_clr,
    output logic              err_underrun,
    output logic              err_overflow,
`endif
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    input  logic [DATA_W-1:0] ext_in_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    output logic [DATA_W-1:0] ext_out_data
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int OUT_CW = OUT_AW + 1;

    localparam logic [IN_CW-1:0]  IN_FULL_CNT  = IN_CW'(IN_DEPTH);
    localparam logic [OUT_CW-1:0] OUT_FULL_CNT = OUT_CW'(OUT_DEPTH);

    // -----------------------------------------------------------------------
    // Input FIFO (external producer -> processor IN)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] inMem [IN_DEPTH];
    logic [IN_AW-1:0]  inWrPtr;
    logic [IN_AW-1:0]  inRdPtr;
    logic [IN_CW-1:0]  inCount;
    logic [IN_CW-1:0]  inCountNext;
    logic              inReady;
    logic              inEmpty;
    logic              inPush;
    logic              inPop;
    logic [DATA_W-1:0] inLastWord;

    assign inEmpty = (inCount == '0);
    // inReady is registered "not full"; a same-cycle pop is not credited,
    // so a push can never land on a full FIFO.
    assign inPush  = ext_in_valid & inReady;
    assign inPop   = cpu_in_rd & ~inEmpty;

    always_comb begin
        inCountNext = inCount;
        if (inPush && !inPop) begin
            inCountNext = inCount + IN_CW'(1);
        end else if (inPop && !inPush) begin
            inCountNext = inCount - IN_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inWrPtr    <= '0;
            inRdPtr    <= '0;
            inCount    <= '0;
            inReady    <= 1'b0;
            inLastWord <= '0;
        end else begin
            if (inPush) begin
                inWrPtr <= inWrPtr + IN_AW'(1);
            end
            if (inPop) begin
                inRdPtr    <= inRdPtr + IN_AW'(1);
                inLastWord <= inMem[inRdPtr];
            end
            inCount <= inCountNext;
            inReady <= (inCountNext != IN_FULL_CNT);
        end
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (inPush) begin
            inMem[inWrPtr] <= ext_in_data;
        end
    end

    assign cpu_in_empty = inEmpty;
    // When empty, show the last consumed word rather than stale storage.
    assign cpu_in_data  = inEmpty ? inLastWord : inMem[inRdPtr];
    assign ext_in_ready = inReady;

    // -----------------------------------------------------------------------
    // Output FIFO (processor OUT -> external consumer)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] outMem [OUT_DEPTH];
    logic [OUT_AW-1:0] outWrPtr;
    logic [OUT_AW-1:0] outRdPtr;
    logic [OUT_CW-1:0] outCount;
    logic [OUT_CW-1:0] outCountNext;
    logic              outEmpty;
    logic              outFull;
    logic              outPush;
    logic              outPop;
    logic [DATA_W-1:0] outLastWord;

    assign outEmpty = (outCount == '0);
    assign outFull  = (outCount == OUT_FULL_CNT);
    // Full is judged before any same-cycle pop: the OUT is refused and retried.
    assign outPush  = cpu_out_wr & ~outFull;
    assign outPop   = ~outEmpty & ext_out_ready;

    always_comb begin
        outCountNext = outCount;
        if (outPush && !outPop) begin
            outCountNext = outCount + OUT_CW'(1);
        end else if (outPop && !outPush) begin
            outCountNext = outCount - OUT_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outWrPtr    <= '0;
            outRdPtr    <= '0;
            outCount    <= '0;
            outLastWord <= '0;
        end else begin
            if (outPush) begin
                outWrPtr <= outWrPtr + OUT_AW'(1);
            end
            if (outPop) begin
                outRdPtr    <= outRdPtr + OUT_AW'(1);
                outLastWord <= outMem[outRdPtr];
            end
            outCount <= outCountNext;
        end
    end

    always_ff @(posedge clk) begin
        if (outPush) begin
            outMem[outWrPtr] <= cpu_out_data;
        end
    end

    assign cpu_out_full  = outFull;
    assign ext_out_valid = ~outEmpty;
    assign ext_out_data  = outEmpty ? outLastWord : outMem[outRdPtr];

    // -----------------------------------------------------------------------
    // Stall request
    // -----------------------------------------------------------------------
    logic underrunHit;
    logic overflowHit;

    assign underrunHit = cpu_in_rd & inEmpty;
    assign overflowHit = cpu_out_wr & outFull;
    // Held low while in reset so the pipeline is never frozen by a FIFO that
    // only looks empty because it is being cleared.
    assign stall       = rst & (underrunHit | overflowHit);

`ifdef IOP_ERR_FLAGS_EN
    // -----------------------------------------------------------------------
    // Sticky error flags; a new event outranks a same-cycle clear.
    // -----------------------------------------------------------------------
    logic errUnderrunQ;
    logic errOverflowQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            errUnderrunQ <= 1'b0;
            errOverflowQ <= 1'b0;
        end else begin
            errUnderrunQ <= underrunHit | (errUnderrunQ & ~err_clr);
            errOverflowQ <= overflowHit | (errOverflowQ & ~err_clr);
        end
    end

    assign err_underrun = errUnderrunQ;
    assign err_overflow = errOverflowQ;
`endif

endmodule

// File: tb/tb_io_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_port_ctrl
//
// Self-checking bench for io_port_ctrl. A queue-based reference model tracks
// both FIFOs, the registered ready and the error flags. Every cycle the DUT
// outputs are compared against it. Directed sequences cover reset, ordering,
// full/empty and wrap cases; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_io_port_ctrl;

    localparam int DATA_W    = 16;
    localparam int IN_DEPTH  = 4;
    localparam int OUT_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpuInRd;
    logic [DATA_W-1:0] cpuInData;
    logic              cpuInEmpty;
    logic              cpuOutWr;
    logic [DATA_W-1:0] cpuOutData;
    logic              cpuOutFull;
    logic              stall;
    logic              extInValid;
    logic              extInReady;
    logic [DATA_W-1:0] extInData;
    logic              extOutValid;
    logic              extOutReady;
    logic [DATA_W-1:0] extOutData;
`ifdef IOP_ERR_FLAGS_EN
    logic              errClr;
    logic              errUnderrun;
    logic              errOverflow;
`endif

    always #5 clk = ~clk;

    io_port_ctrl #(
        .DATA_W   (DATA_W),
        .IN_DEPTH (IN_DEPTH),
        .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_in_rd    (cpuInRd),
        .cpu_in_data  (cpuInData),
        .cpu_in_empty (cpuInEmpty),
        .cpu_out_wr   (cpuOutWr),
        .cpu_out_data (cpuOutData),
        .cpu_out_full (cpuOutFull),
        .stall        (stall),
`ifdef IOP_ERR_FLAGS_EN
        .err_clr      (errClr),
        .err_underrun (errUnderrun),
        .err_overflow (errOverflow),
`endif
        .ext_in_valid (extInValid),
        .ext_in_ready (extInReady),
        .ext_in_data  (extInData),
        .ext_out_valid(extOutValid),
        .ext_out_ready(extOutReady),
        .ext_out_data (extOutData)
    );

    int vecCount = 0;
    int errCount = 0;

    // Reference model state
    logic [DATA_W-1:0] inQ[$];
    logic [DATA_W-1:0] outQ[$];
    logic [DATA_W-1:0] mInLast;
    logic [DATA_W-1:0] mOutLast;
    logic              mInReady;
    logic              mErrU;
    logic              mErrO;

    // DUT outputs observed just before the most recent active edge
    logic [DATA_W-1:0] obsInData;
    logic [DATA_W-1:0] obsOutData;
    logic              obsInReady;
    logic              obsInEmpty;
    logic              obsStall;
    logic              obsOutValid;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        logic expStall;
        expStall = rst && ((cpuInRd && inQ.size() == 0) || (cpuOutWr && outQ.size() == OUT_DEPTH));
        checkVal("inEmpty",  cpuInEmpty,  inQ.size() == 0);
        checkVal("inData",   cpuInData,   (inQ.size() != 0) ? inQ[0] : mInLast);
        checkVal("inReady",  extInReady,  mInReady);
        checkVal("outFull",  cpuOutFull,  outQ.size() == OUT_DEPTH);
        checkVal("outValid", extOutValid, outQ.size() != 0);
        checkVal("outData",  extOutData,  (outQ.size() != 0) ? outQ[0] : mOutLast);
        checkVal("stall",    stall,       expStall);
`ifdef IOP_ERR_FLAGS_EN
        checkVal("errUnder", errUnderrun, mErrU);
        checkVal("errOver",  errOverflow, mErrO);
`endif
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic modelEdge();
        logic inEmp, outFul, inPush, inPop, outPush, outPop;
        inEmp   = (inQ.size() == 0);
        outFul  = (outQ.size() == OUT_DEPTH);
        inPush  = extInValid && mInReady;
        inPop   = cpuInRd && !inEmp;
        outPush = cpuOutWr && !outFul;
        outPop  = (outQ.size() != 0) && extOutReady;
`ifdef IOP_ERR_FLAGS_EN
        mErrU = (cpuInRd && inEmp) || (mErrU && !errClr);
        mErrO = (cpuOutWr && outFul) || (mErrO && !errClr);
`endif
        if (inPop)   mInLast = inQ.pop_front();
        if (inPush)  inQ.push_back(extInData);
        if (outPop)  mOutLast = outQ.pop_front();
        if (outPush) outQ.push_back(cpuOutData);
        mInReady = (inQ.size() < IN_DEPTH);
    endtask

    // Entered one time unit after a rising edge with inputs already driven.
    task automatic stepCycle();
        @(negedge clk);
        checkAll();
        obsInData   = cpuInData;
        obsOutData  = extOutData;
        obsInReady  = extInReady;
        obsInEmpty  = cpuInEmpty;
        obsStall    = stall;
        obsOutValid = extOutValid;
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpuInRd     = 1'b0;
        cpuOutWr    = 1'b0;
        cpuOutData  = '0;
        extInValid  = 1'b0;
        extInData   = '0;
        extOutReady = 1'b0;
`ifdef IOP_ERR_FLAGS_EN
        errClr      = 1'b0;
`endif
    endtask

    // Assert reset asynchronously while whatever traffic is driven stays put.
    task automatic applyReset(input int cycles);
        rst = 1'b0;
        inQ.delete();
        outQ.delete();
        mInLast  = '0;
        mOutLast = '0;
        mInReady = 1'b0;
        mErrU    = 1'b0;
        mErrO    = 1'b0;
        #1;
        checkAll();
        checkVal("rstInEmpty",  cpuInEmpty,  1);
        checkVal("rstOutValid", extOutValid, 0);
        checkVal("rstInReady",  extInReady,  0);
        checkVal("rstStall",    stall,       0);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            checkAll();
        end
        idle();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int idx;
        int got;
        logic pushed;
        logic [DATA_W-1:0] expW;
        logic [DATA_W-1:0] orderWords [3];

        idle();
        rst = 1'b0;
        mInLast = '0; mOutLast = '0; mInReady = 1'b0; mErrU = 1'b0; mErrO = 1'b0;
        @(posedge clk);
        #1;

        // Reset with traffic driven
        cpuInRd = 1'b1; cpuOutWr = 1'b1; extInValid = 1'b1; extOutReady = 1'b1;
        extInData = 16'h1234; cpuOutData = 16'h5678;
        applyReset(2);
        stepCycle();
        checkVal("rstRelReady0", obsInReady, 0);
        checkVal("rstRelReady1", extInReady, 1);

        // Input ordering
        orderWords[0] = 16'h1111; orderWords[1] = 16'h2222; orderWords[2] = 16'h3333;
        extInValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            extInData = orderWords[k];
            stepCycle();
        end
        extInValid = 1'b0;
        cpuInRd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkVal("inOrder", obsInData, orderWords[k]);
        end
        cpuInRd = 1'b0;
        stepCycle();
        checkVal("inOrderEmpty", obsInEmpty, 1);
        checkVal("inOrderHold", obsInData, 16'h3333);

        // Input full: producer holds the 5th word until space appears
        idx = 0;
        extInValid = 1'b1;
        for (int c = 0; c < 12 && idx < 4; c++) begin
            extInData = 16'(idx + 1);
            stepCycle();
            if (obsInReady) idx++;
        end
        checkVal("inFullPushes", idx, 4);
        checkVal("inFullReady", extInReady, 0);
        extInData = 16'h0005;
        stepCycle();
        stepCycle();
        checkVal("inFullHeld", obsInReady, 0);
        cpuInRd = 1'b1;
        stepCycle();
        checkVal("inFullPop1", obsInData, 16'h0001);
        cpuInRd = 1'b0;
        pushed = 1'b0;
        for (int c = 0; c < 6 && !pushed; c++) begin
            stepCycle();
            if (obsInReady) pushed = 1'b1;
        end
        checkVal("in5Pushed", pushed, 1);
        extInValid = 1'b0;
        cpuInRd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            checkVal("inFullDrain", obsInData, k + 2);
        end
        cpuInRd = 1'b0;
        stepCycle();
        checkVal("inFullEmpty", obsInEmpty, 1);

        // Underrun stall, then a word arrives during the retried IN
        cpuInRd = 1'b1;
        stepCycle();
        checkVal("underStall", obsStall, 1);
        extInValid = 1'b1;
        extInData = 16'hBEEF;
        stepCycle();
        checkVal("underStall2", obsStall, 1);
        extInValid = 1'b0;
        stepCycle();
        checkVal("beefStall", obsStall, 0);
        checkVal("beefData", obsInData, 16'hBEEF);
        cpuInRd = 1'b0;
`ifdef IOP_ERR_FLAGS_EN
        stepCycle();
        stepCycle();
        checkVal("errUnderSticky", errUnderrun, 1);
        errClr = 1'b1;
        stepCycle();
        errClr = 1'b0;
        checkVal("errUnderClr", errUnderrun, 0);
`endif

        // Output backpressure
        idle();
        cpuOutWr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cpuOutData = 16'(16'h00A0 + k);
            stepCycle();
            checkVal("outWrOk", obsStall, 0);
        end
        checkVal("outFullFlag", cpuOutFull, 1);
        cpuOutData = 16'h00A4;
        stepCycle();
        checkVal("outWr5Stall", obsStall, 1);
        checkVal("outHeadStable", obsOutData, 16'h00A0);
        stepCycle();
        checkVal("outHeadStable2", obsOutData, 16'h00A0);
        extOutReady = 1'b1;
        got = 0;
        for (int c = 0; c < 12 && got < 5; c++) begin
            stepCycle();
            if (obsOutValid) begin
                checkVal("outDrain", obsOutData, 16'h00A0 + got);
                got++;
            end
            if (!obsStall) cpuOutWr = 1'b0;
        end
        checkVal("outDrainCnt", got, 5);
        idle();
        stepCycle();

        // Wrap with continuous simultaneous push/pop on both FIFOs
`ifdef IOP_ERR_FLAGS_EN
        errClr = 1'b1;
        stepCycle();
        errClr = 1'b0;
`endif
        extInValid = 1'b1;
        cpuOutWr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            extInData  = 16'(16'h00F0 + k);
            cpuOutData = 16'(16'h00F0 + k);
            stepCycle();
        end
        cpuInRd = 1'b1;
        extOutReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            extInData  = 16'(16'h0100 + i);
            cpuOutData = 16'(16'h0100 + i);
            stepCycle();
            expW = (i < 2) ? 16'(16'h00F0 + i) : 16'(16'h0100 + i - 2);
            checkVal("wrapStall", obsStall, 0);
            checkVal("wrapIn", obsInData, expW);
            checkVal("wrapOut", obsOutData, expW);
            checkVal("wrapInReady", obsInReady, 1);
            checkVal("wrapOutValid", obsOutValid, 1);
`ifdef IOP_ERR_FLAGS_EN
            checkVal("wrapErrU", errUnderrun, 0);
            checkVal("wrapErrO", errOverflow, 0);
`endif
        end
        idle();
        cpuInRd = 1'b1;
        extOutReady = 1'b1;
        repeat (4) stepCycle();
        idle();
        stepCycle();

        // Randomized traffic with a reset in the middle
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                cpuInRd = 1'b1; extInValid = 1'b1; cpuOutWr = 1'b1;
                applyReset(2);
            end
            if (c < 200) begin
                extInValid  = ($urandom % 4) != 0;
                cpuInRd     = ($urandom % 3) == 0;
                cpuOutWr    = ($urandom % 4) != 0;
                extOutReady = ($urandom % 3) == 0;
            end else begin
                extInValid  = ($urandom % 3) == 0;
                cpuInRd     = ($urandom % 4) != 0;
                cpuOutWr    = ($urandom % 3) == 0;
                extOutReady = ($urandom % 4) != 0;
            end
            extInData  = 16'($urandom);
            cpuOutData = 16'($urandom);
`ifdef IOP_ERR_FLAGS_EN
            errClr = ($urandom % 8) == 0;
`endif
            stepCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
